ttl_74165: RTL and testbench
============================

# ttl_74165

Synchronous model of a 74165-style 8-bit parallel-in, serial-out shift register. It is the transmit end of the serial links built from the library's TTL parts, and it pairs with the serial-in/parallel-out receivers. A parallel word is captured, then shifted out MSB-first (pin H) on QH/QH_n, with cascade input SER filling from the A end. The model adds an active-high asynchronous clear for clean simulation start-up.

## Interface
- WIDTH, 8: shift register length; bit WIDTH-1 is pin H, bit 0 is pin A.
- DELAY_RISE, 12: output low-to-high delay in ns; used only with TTL_DELAY_EN.
- DELAY_FALL, 16: output high-to-low delay in ns; used only with TTL_DELAY_EN.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous, active-high reset.
- SH_LD_n  input  1  0 = parallel load, 1 = shift/hold; sampled at the CLK edge.
- CLK_INH  input  1  1 = inhibit shifting; sampled at the CLK edge.
- SER  input  1  serial data into bit 0 (pin A) on shift.
- D  input  WIDTH  parallel data; D[WIDTH-1] = H, D[0] = A.
- QH  output  1  serial output, equal to register bit WIDTH-1.
- QH_n  output  1  complement of QH.

One clock; reset is asynchronous and active-high (ports CLK and CLR).

## Operation
- Internal state is SR[WIDTH-1:0]. There is no other state.
- CLR=1 clears SR to 0 immediately, independent of CLK. QH=0 and QH_n=1 while CLR is held.
- At each rising CLK edge with CLR=0, the priority order is:
  - SH_LD_n=0: SR <= D. Load takes priority over CLK_INH.
  - SH_LD_n=1, CLK_INH=0: SR <= {SR[WIDTH-2:0], SER}, shifting toward H.
  - SH_LD_n=1, CLK_INH=1: SR holds.
- QH = SR[WIDTH-1] and QH_n = ~SR[WIDTH-1], driven combinationally from the register.
- Word sequence after a load: QH shows D[7], then D[6] … D[0] on the next 7 shifts. The 8th shift presents the first SER bit, so cascaded parts chain QH into the next part's SER.
- Load is synchronous in this model, not asynchronous as on the datasheet part. Inhibit is a synchronous enable, not an OR with CLK.
- Inputs are not registered beyond SR. An X on SH_LD_n or CLK_INH at an edge propagates X into SR.

## Timing
- Load latency: QH = D[WIDTH-1] immediately after the load edge (1 edge).
- Shift latency: 1 edge per bit. A full word drains in WIDTH shifts after the load edge.
- Reset mid-shift: SR is cleared at once and the remaining bits are lost. The first edge after CLR falls performs normal load/shift.
- CLR high at a CLK edge: clear wins and the edge is ignored.
- Load and shift in consecutive cycles need no idle cycle between them.
- Back-to-back loads: the last load wins, and no bit is shifted.

## Configuration
- TTL_DELAY_EN defined:
  - QH and QH_n update through inertial delays.
  - The delay is DELAY_RISE ns for 0→1 and DELAY_FALL ns for 1→0.
  - This applies to clock-driven and CLR-driven changes alike.
  - Benches must sample at least DELAY_FALL after an edge.
- TTL_DELAY_EN undefined: outputs follow SR with zero delay. Behaviour is otherwise identical.

## Test plan
- Reset: assert CLR at t=0 with CLK idle → QH=0, QH_n=1. Hold CLR and apply 3 edges with SH_LD_n=0 and D=8'hFF → QH stays 0.
- Load/shift: load D=8'hA5, then 8 shifts with SER=0, CLK_INH=0 → QH sequence 1,0,1,0,0,1,0,1 (post-load through 7th shift), then 0 after the 8th shift. QH_n is always the complement.
- Inhibit/priority: load 8'h80, CLK_INH=1, 4 edges with SH_LD_n=1 → QH stays 1. Then SH_LD_n=0, D=8'h00, CLK_INH=1, 1 edge → QH=0 (load beats inhibit).
- Cascade fill: load 8'h00, SER=1, 8 shifts → QH=0 for edges 1–7 and QH=1 after edge 8. SR=8'hFF, confirmed by 8 more shifts with SER=0 giving QH=1,1,1,1,1,1,1,0.
- Mid-shift reset: load 8'hFF, 3 shifts, pulse CLR for 5 ns between edges → QH=0 at once. The next shift with SER=0 keeps QH=0.
- With TTL_DELAY_EN: load 8'h80 from reset → QH rises exactly 12 ns after the edge. Load 8'h00 → QH falls 16 ns after the edge, and QH_n mirrors with the opposite-direction delay.

Source files
------------

// File: rtl/ttl_74165.sv
// ttl_74165 -- synchronous model of a 74165-style parallel-in, serial-out
// shift register. It is the transmit end of the TTL serial links: a parallel
// word is captured, then shifted out MSB-first (pin H) on QH/QH_n. SER fills
// the register from the A end, so a cascade chains QH into the next SER.
//
// Ports:
//   CLK      in   1      rising-edge clock
//   CLR      in   1      asynchronous active-high clear of the register
//   SH_LD_n  in   1      0 = parallel load, 1 = shift/hold (sampled at CLK)
//   CLK_INH  in   1      1 = inhibit shifting (sampled at CLK); load ignores it
//   SER      in   1      serial data into bit 0 (pin A) on a shift
//   D        in   WIDTH  parallel data, D[WIDTH-1] = pin H, D[0] = pin A
//   QH       out  1      register bit WIDTH-1
//   QH_n     out  1      complement of QH
//
// Parameters:
//   WIDTH       register length (at least 2)
//   DELAY_RISE  output 0->1 delay in ns, used only with TTL_DELAY_EN
//   DELAY_FALL  output 1->0 delay in ns, used only with TTL_DELAY_EN
//
// Build option:
//   TTL_DELAY_EN  when defined, QH and QH_n follow the register through
//                 inertial delays (simulation-only timing model). When not
//                 defined, the outputs follow the register with zero delay.

module ttl_74165 #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 12,
    parameter int DELAY_FALL = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             SH_LD_n,
    input  logic             CLK_INH,
    input  logic             SER,
    input  logic [WIDTH-1:0] D,
    output logic             QH,
    output logic             QH_n
);

    // Elaboration-time sanity checks: the shift path slices [WIDTH-2:0],
    // and negative delays are meaningless for the timing model.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("ttl_74165: WIDTH must be at least 2");
        end
        if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
            $error("ttl_74165: delays must be non-negative");
        end
    endgenerate

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_shift;

    // Shift toward H: each bit moves one place up, SER enters at pin A.
    assign sr_shift = {sr_q[WIDTH-2:0], SER};

    // Next-state selection. Written with conditional operators rather than
    // if/else so that an X on SH_LD_n or CLK_INH merges the candidate values
    // bitwise and propagates X into the register instead of silently
    // picking a branch. Load outranks inhibit.
    always_comb begin
        sr_d = sr_q;
        sr_d = (!SH_LD_n) ? D
             : ((!CLK_INH) ? sr_shift : sr_q);
    end

    // Clear acts immediately and also wins over a coincident clock edge.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

`ifdef TTL_DELAY_EN
    // Continuous assignments with rise/fall delays are inertial: a pulse
    // shorter than the delay is swallowed. Each output applies its own
    // direction's delay, so QH_n rises after DELAY_RISE while QH falls
    // after DELAY_FALL. Clear-driven changes go through the same path.
    assign #(DELAY_RISE, DELAY_FALL) QH   = sr_q[WIDTH-1];
    assign #(DELAY_RISE, DELAY_FALL) QH_n = ~sr_q[WIDTH-1];
`else
    assign QH   = sr_q[WIDTH-1];
    assign QH_n = ~sr_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_ttl_74165.sv
module tb_ttl_74165;

    logic       CLK;
    logic       CLR;
    logic       SH_LD_n;
    logic       CLK_INH;
    logic       SER;
    logic [7:0] D;
    logic       QH;
    logic       QH_n;

    int total;
    int bad;

    // Reference: the register contents as a plain integer 0..255.
    int unsigned model;

    ttl_74165 #(
        .WIDTH      (8),
        .DELAY_RISE (12),
        .DELAY_FALL (16)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .SH_LD_n (SH_LD_n),
        .CLK_INH (CLK_INH),
        .SER     (SER),
        .D       (D),
        .QH      (QH),
        .QH_n    (QH_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural view of one clock edge, from the operating rules.
    function automatic int unsigned model_step(input int unsigned cur, input logic ld_n,
                                               input logic inh, input logic ser,
                                               input logic [7:0] d);
        if (!ld_n)     return int'(d);
        else if (!inh) return (cur * 2 + int'(ser)) % 256;
        else           return cur;
    endfunction

    // Drive inputs (already 1 ns past an edge), take the next edge, then
    // sample 1 ns later. The model follows unless CLR is held.
    task automatic tick(input logic ld_n, input logic inh, input logic ser, input logic [7:0] d);
        SH_LD_n = ld_n;
        CLK_INH = inh;
        SER     = ser;
        D       = d;
        @(posedge CLK);
        #1;
        if (CLR) model = 0;
        else     model = model_step(model, ld_n, inh, ser, d);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_qh"},   32'(QH),   32'(model / 128));
        chk({tag, "_qh_n"}, 32'(QH_n), 32'(1 - model / 128));
    endtask

    logic [7:0] a5_bits;

    initial begin
        total   = 0;
        bad     = 0;
        model   = 0;
        CLR     = 1'b1;
        SH_LD_n = 1'b1;
        CLK_INH = 1'b0;
        SER     = 1'b0;
        D       = 8'h00;

        // Clear before any clock edge.
        #1;
        chk("rst_qh", 32'(QH), 32'd0);
        chk("rst_qh_n", 32'(QH_n), 32'd1);

        // Clear held across edges that would otherwise load all ones.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 8'hFF);
            chk($sformatf("rst_hold%0d", i), 32'(QH), 32'd0);
        end
        CLR = 1'b0;

        // Load A5 then shift with SER=0: H..A then the first SER bit.
        a5_bits = 8'hA5;
        tick(1'b0, 1'b0, 1'b0, 8'hA5);
        chk("a5_load", 32'(QH), 32'(a5_bits[7]));
        chk_out("a5_load_m");
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("a5_sh%0d", i), 32'(QH), (i < 8) ? 32'(a5_bits[7 - i]) : 32'd0);
            chk_out($sformatf("a5_sh%0d_m", i));
        end

        // Inhibit holds; load beats inhibit.
        tick(1'b0, 1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0, 8'h00);
            chk($sformatf("inh%0d", i), 32'(QH), 32'd1);
        end
        tick(1'b0, 1'b1, 1'b1, 8'h00);
        chk("ld_over_inh", 32'(QH), 32'd0);
        chk_out("ld_over_inh_m");

        // Cascade fill from SER, then drain the ones back out.
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 1'b1, 8'h00);
            chk($sformatf("fill%0d", i), 32'(QH), (i == 8) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("drain%0d", i), 32'(QH), (i == 8) ? 32'd0 : 32'd1);
        end

        // Back-to-back loads: the last one wins, nothing shifts.
        tick(1'b0, 1'b0, 1'b1, 8'h7F);
        tick(1'b0, 1'b0, 1'b1, 8'hC0);
        chk("b2b_ld0", 32'(QH), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        chk("b2b_ld1", 32'(QH), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        chk("b2b_ld2", 32'(QH), 32'd0);

        // Mid-shift clear pulse between edges.
        tick(1'b0, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
        chk("pre_clr", 32'(QH), 32'd1);
        #1 CLR = 1'b1;
        #1;
        chk("clr_now", 32'(QH), 32'd0);
        chk("clr_now_n", 32'(QH_n), 32'd1);
        #4 CLR = 1'b0;
        model = 0;
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        chk("post_clr", 32'(QH), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 8'h80);
        chk("post_clr_ld", 32'(QH), 32'd1);

        // Randomized traffic against the model, with occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic ld_n, inh, ser;
            logic [7:0] d;
            ld_n = ($urandom_range(0, 5) != 0);
            inh  = ($urandom_range(0, 3) == 0);
            ser  = 1'($urandom);
            d    = 8'($urandom);
            tick(ld_n, inh, ser, d);
            chk_out($sformatf("rnd%0d", i));
            if ($urandom_range(0, 40) == 0) begin
                #1 CLR = 1'b1;
                model = 0;
                #2;
                chk_out($sformatf("rnd_clr%0d", i));
                CLR = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
